// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared types and defaults for the SoC memory front end.
package sopc_mem_arbiter_pkg;

  // Transaction FSM states: one transaction outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Arbitration policy selectors.
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Default guest memory window.
  localparam logic [31:0] SOPC_MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] SOPC_MEM_SIZE = 32'h0800_0000;

endpackage

// File: rtl/sopc_mem_arbiter_if.sv
// Bundle of master-channel and backing-memory signals seen by the arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of the bus masters plus the memory model.
interface sopc_mem_arbiter_if #(
  parameter int N_CH = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int MW   = DW / 8
);
  logic [N_CH-1:0]    ch_req;
  logic [N_CH-1:0]    ch_we;
  logic [N_CH*AW-1:0] ch_addr;
  logic [N_CH*DW-1:0] ch_wdata;
  logic [N_CH*MW-1:0] ch_mask;
  logic [N_CH*DW-1:0] ch_rdata;
  logic [N_CH-1:0]    ch_ready;
  logic [N_CH-1:0]    ch_err;
  logic               mem_req;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [MW-1:0]      mem_mask;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  ch_req, ch_we, ch_addr, ch_wdata, ch_mask, mem_rdata,
    output ch_rdata, ch_ready, ch_err, mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output ch_req, ch_we, ch_addr, ch_wdata, ch_mask, mem_rdata,
    input  ch_rdata, ch_ready, ch_err, mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/sopc_rr_arbiter.sv
// Combinational request arbiter: fixed priority (lowest index wins) or
// round-robin starting one past the last granted channel.
module sopc_rr_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int IW   = 1
) (
  input  logic            mode,
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            valid
);

  int base;
  int cand;

  // Scan channels from the policy's start point and take the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    base      = (mode == ARB_RR) ? int'(ptr) + 1 : 0;
    cand      = 0;
    for (int off = 0; off < N_CH; off++) begin
      cand = (base + off) % N_CH;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant_idx   = IW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// N-channel memory front end: arbitrates master channels onto one
// fixed-latency memory port, translates the guest base address away and
// answers out-of-window accesses with an error response.
module sopc_mem_arbiter
  import sopc_mem_arbiter_pkg::*;
#(
  parameter int            N_CH     = 2,
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            MW       = DW / 8,
  parameter logic [AW-1:0] MEM_BASE = AW'(SOPC_MEM_BASE),
  parameter logic [AW-1:0] MEM_SIZE = AW'(SOPC_MEM_SIZE),
  parameter int            MEM_LAT  = 1,
  parameter int            ARB_MODE = 1
) (
  input logic               clk,
  input logic               rst,
  sopc_mem_arbiter_if.slave bus
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  arb_state_e         state_reg;
  arb_state_e         state_next;
  logic [IW-1:0]      gnt_reg;
  logic [IW-1:0]      ptr_reg;
  logic               we_reg;
  logic               err_reg;
  logic [AW-1:0]      off_reg;
  logic [DW-1:0]      wdata_reg;
  logic [MW-1:0]      mask_reg;
  logic [DW-1:0]      rdata_reg;
  logic [3:0]         cnt_reg;

  logic [N_CH-1:0]    arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;

  wire  [AW-1:0]      addr_a  [N_CH];
  wire  [DW-1:0]      wdata_a [N_CH];
  wire  [MW-1:0]      mask_a  [N_CH];

  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [AW-1:0]      sel_off;
  logic               sel_fault;
  logic               busy;

  logic [N_CH-1:0]    ready_vec;
  logic [N_CH-1:0]    err_vec;
  logic [N_CH*DW-1:0] rdata_vec;

  // Split the flat channel buses into per-channel fields.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_split
    assign addr_a[gi]  = bus.ch_addr[gi*AW +: AW];
    assign wdata_a[gi] = bus.ch_wdata[gi*DW +: DW];
    assign mask_a[gi]  = bus.ch_mask[gi*MW +: MW];
  end

  sopc_rr_arbiter #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_arb (
    .mode      ((ARB_MODE == 0) ? ARB_FIXED : ARB_RR),
    .req       (bus.ch_req),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // Granted request fields and window check; the offset wraps in AW bits.
  always_comb begin
    sel_we    = |(bus.ch_we & arb_grant);
    sel_addr  = addr_a[arb_idx];
    sel_off   = sel_addr - MEM_BASE;
    sel_fault = (sel_addr < MEM_BASE) || (sel_off >= MEM_SIZE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // FSM next state: faults skip the memory and answer straight away.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (arb_valid) state_next = sel_fault ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_next = (MEM_LAT == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (cnt_reg == 4'd1) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request latch, round-robin pointer, latency counter and read capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_reg   <= '0;
      ptr_reg   <= IW'(N_CH - 1);
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      off_reg   <= '0;
      wdata_reg <= '0;
      mask_reg  <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt_reg   <= arb_idx;
            ptr_reg   <= arb_idx;
            we_reg    <= sel_we;
            err_reg   <= sel_fault;
            off_reg   <= sel_off;
            wdata_reg <= wdata_a[arb_idx];
            mask_reg  <= sel_we ? mask_a[arb_idx] : '0;
            rdata_reg <= '0;
          end
        end
        ST_ISSUE: begin
          cnt_reg <= 4'(MEM_LAT);
          if (MEM_LAT == 0 && !we_reg) rdata_reg <= bus.mem_rdata;
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1 && !we_reg) rdata_reg <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Response demux: only the granted channel sees ready/err/rdata.
  always_comb begin
    ready_vec = '0;
    err_vec   = '0;
    rdata_vec = '0;
    if (state_reg == ST_RESP) begin
      ready_vec[gnt_reg]           = 1'b1;
      err_vec[gnt_reg]             = err_reg;
      rdata_vec[gnt_reg*DW +: DW]  = rdata_reg;
    end
  end

  assign busy          = (state_reg != ST_IDLE);
  assign bus.ch_ready  = ready_vec;
  assign bus.ch_err    = err_vec;
  assign bus.ch_rdata  = rdata_vec;
  assign bus.mem_req   = (state_reg == ST_ISSUE);
  assign bus.mem_we    = busy && we_reg;
  assign bus.mem_addr  = busy ? off_reg   : '0;
  assign bus.mem_wdata = busy ? wdata_reg : '0;
  assign bus.mem_mask  = busy ? mask_reg  : '0;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench: four arbiter instances with different latency/policy
// share one clock and reset; each has its own fixed-latency memory model.
module tb_sopc_mem_arbiter;

  localparam int NI = 4;
  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [NC-1:0]    s_req   [NI];
  logic [NC-1:0]    s_we    [NI];
  logic [NC*AW-1:0] s_addr  [NI];
  logic [NC*DW-1:0] s_wdata [NI];
  logic [NC*MW-1:0] s_mask  [NI];

  wire  [NC-1:0]    o_ready  [NI];
  wire  [NC-1:0]    o_err    [NI];
  wire  [NC*DW-1:0] o_rdata  [NI];
  wire              o_mreq   [NI];
  wire              o_mwe    [NI];
  wire  [AW-1:0]    o_maddr  [NI];
  wire  [DW-1:0]    o_mwdata [NI];
  wire  [MW-1:0]    o_mmask  [NI];

  // Memory contents seen by reads (offset address in, data out).
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: lat 2 RR; 1: lat 0 fixed; 2: lat 15 RR; 3: lat 3 RR.
  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT  = (gi == 0) ? 2 : (gi == 1) ? 0 : (gi == 2) ? 15 : 3;
    localparam int MODE = (gi == 1) ? 0 : 1;

    sopc_mem_arbiter_if #(.N_CH(NC), .AW(AW), .DW(DW), .MW(MW)) bus ();

    logic [4:0]  m_cnt  = 5'd0;
    logic [31:0] m_held = 32'd0;

    always @(posedge clk) begin
      if (bus.mem_req) begin
        m_held <= mem_f(bus.mem_addr);
        m_cnt  <= 5'(LAT);
      end else if (m_cnt != 5'd0) begin
        m_cnt <= m_cnt - 5'd1;
      end
    end

    assign bus.mem_rdata = (LAT == 0) ? (bus.mem_req ? mem_f(bus.mem_addr) : JUNK)
                                      : ((m_cnt == 5'd1) ? m_held : JUNK);
    assign bus.ch_req    = s_req[gi];
    assign bus.ch_we     = s_we[gi];
    assign bus.ch_addr   = s_addr[gi];
    assign bus.ch_wdata  = s_wdata[gi];
    assign bus.ch_mask   = s_mask[gi];
    assign o_ready[gi]   = bus.ch_ready;
    assign o_err[gi]     = bus.ch_err;
    assign o_rdata[gi]   = bus.ch_rdata;
    assign o_mreq[gi]    = bus.mem_req;
    assign o_mwe[gi]     = bus.mem_we;
    assign o_maddr[gi]   = bus.mem_addr;
    assign o_mwdata[gi]  = bus.mem_wdata;
    assign o_mmask[gi]   = bus.mem_mask;

    sopc_mem_arbiter #(
      .N_CH(NC), .AW(AW), .DW(DW), .MW(MW), .MEM_LAT(LAT), .ARB_MODE(MODE)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  // Transaction results filled in by run_txn.
  int          r_lat, r_nreq, r_req_at;
  logic [1:0]  r_rdy, r_err;
  logic [31:0] r_rdata, r_maddr, r_mwdata;
  logic        r_mwe;
  logic [3:0]  r_mmask;

  // Raise the requests in an idle cycle T, then observe each later cycle
  // (offset c = cycles after T) until a ready pulse or the cycle budget ends.
  task automatic run_txn(input int k, input logic [1:0] rq, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask);
    @(posedge clk); #1;
    s_req[k]   = rq;
    s_we[k]    = {we, we};
    s_addr[k]  = {addr, addr};
    s_wdata[k] = {wdata, wdata};
    s_mask[k]  = {mask, mask};
    r_lat = -1; r_nreq = 0; r_req_at = -1; r_rdy = '0; r_err = '0; r_rdata = JUNK;
    r_maddr = JUNK; r_mwdata = JUNK; r_mwe = 1'bx; r_mmask = 4'hx;
    for (int c = 1; c <= 40 && r_lat < 0; c++) begin
      @(posedge clk); #1;
      if (o_mreq[k]) begin
        r_nreq++;
        if (r_req_at < 0) begin
          r_req_at = c; r_maddr = o_maddr[k]; r_mwe = o_mwe[k];
          r_mwdata = o_mwdata[k]; r_mmask = o_mmask[k];
        end
      end
      if (o_ready[k] != '0) begin
        r_lat   = c;
        r_rdy   = o_ready[k];
        r_err   = o_err[k];
        r_rdata = r_rdy[1] ? o_rdata[k][63:32] : o_rdata[k][31:0];
        s_req[k] = '0;
      end
    end
    s_req[k] = '0;
    $display("txn inst=%0d req=%b we=%0d addr=%h ready=%b err=%b rdata=%h lat=%0d mem_req=%0d",
             k, rq, we, addr, r_rdy, r_err, r_rdata, r_lat, r_nreq);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({o_ready[k], o_err[k], o_rdata[k], o_mreq[k], o_mwe[k], o_maddr[k],
           o_mwdata[k], o_mmask[k]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d: ready=%b mem_req=%b mem_addr=%h required all zero",
                 k, o_ready[k], o_mreq[k], o_maddr[k]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    @(posedge clk); #1;
    s_req[3] = 2'b01; s_we[3] = 2'b00;
    s_addr[3] = {32'h8000_0020, 32'h8000_0020};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({o_ready[3], o_mreq[3], o_maddr[3], o_mmask[3]} !== '0) begin
      errors++;
      $display("FAIL midwait_reset_outputs: ready=%b mem_req=%b mem_addr=%h required 0",
               o_ready[3], o_mreq[3], o_maddr[3]);
    end
    s_req[3] = '0;
    @(posedge clk); #1 rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (o_ready[3] != '0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midwait_no_ready: %0d ready pulses after reset, required 0", seen);
    end
    run_txn(3, 2'b11, 1'b0, 32'h8000_0040, 32'h0, 4'h0);
    checks++;
    if (r_rdy !== 2'b01) begin
      errors++;
      $display("FAIL midwait_first_grant: ready=%b required 01", r_rdy);
    end
    checks++;
    if (r_lat !== 5) begin
      errors++;
      $display("FAIL midwait_latency: lat=%0d required 5", r_lat);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp;
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 2'b11, 1'b0, 32'h8000_0100, 32'h0, 4'h0);
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (r_rdy !== exp) begin
        errors++;
        $display("FAIL rr_grant[%0d]: ready=%b required %b", i, r_rdy, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      run_txn(1, 2'b11, 1'b0, 32'h8000_0100, 32'h0, 4'h0);
      checks++;
      if (r_rdy !== 2'b01) begin
        errors++;
        $display("FAIL fixed_grant[%0d]: ready=%b required 01", i, r_rdy);
      end
    end
  endtask

  task automatic test_read();
    run_txn(0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
    checks++;
    if (r_req_at !== 1 || r_maddr !== 32'h10) begin
      errors++;
      $display("FAIL read_mem_addr: mem_req at %0d addr %h, required at 1 addr 00000010", r_req_at, r_maddr);
    end
    checks++;
    if (r_mmask !== 4'h0 || r_mwe !== 1'b0) begin
      errors++;
      $display("FAIL read_mem_mask: mask=%b we=%b required 0000/0", r_mmask, r_mwe);
    end
    checks++;
    if (r_lat !== 4 || r_rdy !== 2'b10 || r_err !== 2'b00) begin
      errors++;
      $display("FAIL read_ready: lat=%0d ready=%b err=%b required 4/10/00", r_lat, r_rdy, r_err);
    end
    checks++;
    if (r_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_rdata: %h required deadbeef", r_rdata);
    end
  endtask

  task automatic test_write();
    run_txn(0, 2'b10, 1'b1, 32'h8000_0004, 32'h1122_3344, 4'b0110);
    checks++;
    if (r_mwe !== 1'b1 || r_mmask !== 4'b0110 || r_maddr !== 32'h4 || r_mwdata !== 32'h1122_3344) begin
      errors++;
      $display("FAIL write_mem_fields: we=%b mask=%b addr=%h wdata=%h required 1/0110/00000004/11223344",
               r_mwe, r_mmask, r_maddr, r_mwdata);
    end
    checks++;
    if (r_nreq !== 1 || r_lat !== 4 || r_rdy !== 2'b10) begin
      errors++;
      $display("FAIL write_handshake: mem_req count=%0d lat=%0d ready=%b required 1/4/10", r_nreq, r_lat, r_rdy);
    end
    checks++;
    if (r_rdata !== 32'h0 || r_err !== 2'b00) begin
      errors++;
      $display("FAIL write_rdata: rdata=%h err=%b required 0/00", r_rdata, r_err);
    end
  endtask

  task automatic test_fault();
    logic [31:0] bad [2];
    bad[0] = 32'h7FFF_FFFC;
    bad[1] = 32'h8800_0000;
    for (int i = 0; i < 2; i++) begin
      run_txn(0, 2'b01, 1'b0, bad[i], 32'h0, 4'h0);
      checks++;
      if (r_nreq !== 0 || r_lat !== 1 || r_rdy !== 2'b01 || r_err !== 2'b01 || r_rdata !== 32'h0) begin
        errors++;
        $display("FAIL fault_%h: mem_req=%0d lat=%0d ready=%b err=%b rdata=%h required 0/1/01/01/0",
                 bad[i], r_nreq, r_lat, r_rdy, r_err, r_rdata);
      end
    end
    run_txn(0, 2'b01, 1'b0, 32'h87FF_FFFC, 32'h0, 4'h0);
    checks++;
    if (r_err !== 2'b00 || r_lat !== 4 || r_maddr !== 32'h07FF_FFFC || r_rdata !== mem_f(32'h07FF_FFFC)) begin
      errors++;
      $display("FAIL top_of_window: err=%b lat=%0d addr=%h rdata=%h required 00/4/07fffffc/%h",
               r_err, r_lat, r_maddr, r_rdata, mem_f(32'h07FF_FFFC));
    end
  endtask

  task automatic test_latency_sweep();
    run_txn(1, 2'b01, 1'b0, 32'h8000_0200, 32'h0, 4'h0);
    checks++;
    if (r_lat !== 2 || r_nreq !== 1 || r_req_at !== 1 || r_rdata !== mem_f(32'h200)) begin
      errors++;
      $display("FAIL lat0: lat=%0d mem_req=%0d at %0d rdata=%h required 2/1/1/%h",
               r_lat, r_nreq, r_req_at, r_rdata, mem_f(32'h200));
    end
    run_txn(2, 2'b10, 1'b0, 32'h8000_0300, 32'h0, 4'h0);
    checks++;
    if (r_lat !== 17 || r_nreq !== 1 || r_req_at !== 1 || r_rdata !== mem_f(32'h300)) begin
      errors++;
      $display("FAIL lat15: lat=%0d mem_req=%0d at %0d rdata=%h required 17/1/1/%h",
               r_lat, r_nreq, r_req_at, r_rdata, mem_f(32'h300));
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      s_req[k] = '0; s_we[k] = '0; s_addr[k] = '0; s_wdata[k] = '0; s_mask[k] = '0;
    end
    test_reset();
    test_reset_mid_wait();
    test_arbitration();
    test_read();
    test_write();
    test_fault();
    test_latency_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
